// File: rtl/spike_uart_tx.sv
// rtl/spike_uart_tx.sv - spike word to 8N1 UART transmitter
// Pops one {timestamp, address} word per frame group and sends it MSB byte first.
module spike_uart_tx #(
  parameter int TD_WIDTH      = 16,
  parameter int NEURON_NO     = 256,
  parameter int UART_DATA_LEN = 8,
  parameter int UART_CYC      = 3,
  parameter int CLKS_PER_BIT  = 868,
  localparam int W            = TD_WIDTH + $clog2(NEURON_NO)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_en,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_dout,
  output logic         fifo_rd,
  output logic         tx_dout,
  output logic         busy,
  output logic         word_done,
  output logic [15:0]  word_cnt
);

  localparam int TOT    = UART_DATA_LEN * UART_CYC;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = $clog2(UART_DATA_LEN + 1);
  localparam int BYTE_W = $clog2(UART_CYC + 1);

  if (W > TOT) begin : g_bad_width
    $error("spike_uart_tx: spike word does not fit in UART_CYC frames");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t                   state_q;
  logic [TOT-1:0]           word_q;
  logic [UART_DATA_LEN-1:0] shift_q;
  logic [BIT_W-1:0]         bit_idx_q;
  logic [BYTE_W-1:0]        byte_idx_q;
  logic [BAUD_W-1:0]        baud_q;
  logic                     tx_q;
  logic                     fifo_rd_q;
  logic                     busy_q;
  logic                     word_done_q;
  logic [15:0]              word_cnt_q;

  logic [TOT-1:0] padded;
  logic           bit_end;

  assign padded  = TOT'(fifo_dout);
  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Byte k of the word, counted from the most-significant end.
  function automatic logic [UART_DATA_LEN-1:0] byte_of(input logic [TOT-1:0] w,
                                                       input logic [BYTE_W-1:0] k);
    logic [TOT-1:0] s;
    s = w >> ((UART_CYC - 1 - int'(k)) * UART_DATA_LEN);
    return s[UART_DATA_LEN-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      fifo_rd_q   <= 1'b0;
      word_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_en && !fifo_empty) begin
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_POP;
          end
        end
        S_POP: state_q <= S_LOAD;
        S_LOAD: begin
          word_q     <= padded;
          shift_q    <= byte_of(padded, BYTE_W'(0));
          byte_idx_q <= '0;
          bit_idx_q  <= '0;
          baud_q     <= '0;
          tx_q       <= 1'b0;
          state_q    <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            baud_q    <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == BIT_W'(UART_DATA_LEN - 1)) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            // Next byte starts straight after the stop bit, no idle bit in between.
            if (byte_idx_q < BYTE_W'(UART_CYC - 1)) begin
              byte_idx_q <= byte_idx_q + 1'b1;
              shift_q    <= byte_of(word_q, byte_idx_q + 1'b1);
              tx_q       <= 1'b0;
              state_q    <= S_START;
            end else begin
              word_done_q <= 1'b1;
              word_cnt_q  <= word_cnt_q + 16'd1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign tx_dout   = tx_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_spike_uart_tx.sv
// tb/tb_spike_uart_tx.sv - self-checking bench for spike_uart_tx
// Line decoder and FIFO model live here; expected bytes come from word arithmetic.
module tb_spike_uart_tx;

  localparam int CPB  = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int WORD_CYC = 3 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic        fifo_empty = 1'b1;
  logic [23:0] fifo_dout = '0;
  logic        fifo_rd;
  logic        tx_dout;
  logic        busy;
  logic        word_done;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  spike_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .tx_dout   (tx_dout),
    .busy      (busy),
    .word_done (word_done),
    .word_cnt  (word_cnt)
  );

  logic [23:0] fq[$];
  int cyc = 0;
  int rd_count = 0, rd_cyc = 0, bad_rd = 0;
  int wd_count = 0, wd_cyc = 0;
  int n_cmp = 0, n_fail = 0;
  int exp_rd = 0;
  logic [15:0] exp_cnt = '0;

  // FIFO with one-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd && fq.size() > 0) begin
      fifo_dout <= fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (fifo_rd) begin
      rd_count++;
      rd_cyc = cyc;
      if (fifo_empty) bad_rd++;
    end
    if (word_done) begin
      wd_count++;
      wd_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [23:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    exp_rd++;
  endtask

  function automatic logic [7:0] exp_byte(input logic [23:0] w, input int k);
    return 8'((w >> (8 * (2 - k))) & 24'hFF);
  endfunction

  // Caller is at a negedge; returns at the negedge in the middle of the stop bit.
  task automatic rx_byte(output logic [7:0] b, output int st);
    int n;
    n = 0;
    b = '0;
    while (tx_dout !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    st = cyc;
    if (n >= 3000) begin
      chk("start_timeout", 32'd1, 32'd0);
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    chk("start_bit", tx_dout, 1'b0);
    chk("busy_in_frame", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx_dout;
    end
    repeat (CPB) @(negedge clk);
    chk("stop_bit", tx_dout, 1'b1);
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (wd_count == prev && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("word_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic rx_check(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          output int st0);
    logic [7:0] b;
    logic [7:0] e[3];
    int st[3];
    int prev;
    e[0] = e0; e[1] = e1; e[2] = e2;
    prev = wd_count;
    for (int k = 0; k < 3; k++) begin
      rx_byte(b, st[k]);
      chk($sformatf("byte%0d", k), b, e[k]);
      if (k > 0) chk("byte_spacing", st[k] - st[k-1], BYTE_CYC);
    end
    chk("rd_to_start", st[0] - rd_cyc, 2);
    wait_done(prev);
    chk("word_done_time", wd_cyc - st[0], WORD_CYC);
    exp_cnt = exp_cnt + 16'd1;
    chk("word_cnt", word_cnt, exp_cnt);
    st0 = st[0];
  endtask

  typedef struct {
    logic [23:0] w;
    logic [7:0]  b0, b1, b2;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [7:0] b;
    int s0, s1, s2, prev_wd, rd_before;
    logic [23:0] rw[6];
    bit rd_seen, low_seen, busy_seen;

    tbl[0] = '{24'hA53C81, 8'hA5, 8'h3C, 8'h81};
    tbl[1] = '{24'h000001, 8'h00, 8'h00, 8'h01};
    tbl[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{24'h123456, 8'h12, 8'h34, 8'h56};

    reset = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_dout, 1'b1);
    chk("rst_rd", fifo_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", word_done, 1'b0);
    chk("rst_cnt", word_cnt, 16'd0);
    reset = 1'b1;
    tx_en = 1'b1;

    rd_seen = 0; low_seen = 0; busy_seen = 0;
    repeat (500) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0) rd_seen = 1;
      if (tx_dout !== 1'b1) low_seen = 1;
      if (busy !== 1'b0) busy_seen = 1;
    end
    chk("empty_rd", rd_seen, 1'b0);
    chk("empty_tx", low_seen, 1'b0);
    chk("empty_busy", busy_seen, 1'b0);

    for (int i = 0; i < 4; i++) begin
      push(tbl[i].w);
      rx_check(tbl[i].b0, tbl[i].b1, tbl[i].b2, s0);
      repeat (5) @(negedge clk);
    end

    // Two words queued back to back.
    push(24'h000001);
    push(24'hFFFFFF);
    rx_check(8'h00, 8'h00, 8'h01, s0);
    prev_wd = wd_cyc;
    rx_check(8'hFF, 8'hFF, 8'hFF, s1);
    chk("second_rd_after_done", rd_cyc - prev_wd, 1);
    chk("word_to_word", s1 - s0, WORD_CYC + 3);
    repeat (5) @(negedge clk);

    // tx_en dropped during byte 1: word completes, no further pop.
    push(24'h5A0F33);
    push(24'h777777);
    prev_wd = wd_count;
    rx_byte(b, s0);
    chk("drop_b0", b, 8'h5A);
    repeat (2) @(negedge clk);
    tx_en = 1'b0;
    rx_byte(b, s1);
    chk("drop_b1", b, 8'h0F);
    rx_byte(b, s2);
    chk("drop_b2", b, 8'h33);
    wait_done(prev_wd);
    exp_cnt = exp_cnt + 16'd1;
    rd_before = rd_count;
    repeat (300) @(negedge clk);
    chk("drop_busy", busy, 1'b0);
    chk("drop_no_pop", rd_count, rd_before);
    chk("drop_fifo_left", fq.size(), 1);
    chk("drop_cnt", word_cnt, exp_cnt);
    tx_en = 1'b1;
    rx_check(8'h77, 8'h77, 8'h77, s0);
    repeat (5) @(negedge clk);

    // Reset during DATA of byte 2: line released at once, word abandoned.
    push(24'h123400);
    rx_byte(b, s0);
    chk("rst_mid_b0", b, 8'h12);
    rx_byte(b, s1);
    chk("rst_mid_b1", b, 8'h34);
    repeat (2 + CPB + 3) @(negedge clk);
    chk("pre_rst_line_low", tx_dout, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx_dout, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd", fifo_rd, 1'b0);
    chk("mid_rst_done", word_done, 1'b0);
    chk("mid_rst_cnt", word_cnt, 16'd0);
    exp_cnt = '0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", busy, 1'b0);
    push(24'hC3E196);
    rx_check(8'hC3, 8'hE1, 8'h96, s0);
    repeat (5) @(negedge clk);

    // Randomised burst against the arithmetic byte model.
    for (int i = 0; i < 6; i++) begin
      rw[i] = 24'($urandom());
      push(rw[i]);
    end
    for (int i = 0; i < 6; i++) begin
      rx_check(exp_byte(rw[i], 0), exp_byte(rw[i], 1), exp_byte(rw[i], 2), s1);
      if (i > 0) chk("rand_gap", s1 - s0, WORD_CYC + 3);
      s0 = s1;
    end
    repeat (5) @(negedge clk);

    // Counter wrap: preload just below the top.
    dut.word_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    push(24'h00AA55);
    push(24'h81FF00);
    rx_check(8'h00, 8'hAA, 8'h55, s0);
    rx_check(8'h81, 8'hFF, 8'h00, s1);
    chk("wrap_zero", word_cnt, 16'h0000);
    repeat (10) @(negedge clk);

    chk("rd_while_empty", bad_rd, 0);
    chk("total_pops", rd_count, exp_rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_uart_tx.md
Name: spike_uart_tx

Overview:
- Drains spike events from the spike FIFO and sends them to the PC over the UART TX line. Each event is one word: {timestamp, neuron address}.
- Splits each word into UART_CYC bytes and frames each byte as 8N1 at a fixed baud rate set by a clock divider.
- Sits between the FIFO read port and the board tx_dout pin. It is the transmit-side counterpart of the UART receive path in the system controller.

Parameters:
- TD_WIDTH, 16, timestamp field width.
- NEURON_NO, 256, neuron count. The address field is $clog2(NEURON_NO) bits wide.
- UART_DATA_LEN, 8, data bits per UART frame.
- UART_CYC, 3, bytes per spike word.
- CLKS_PER_BIT, 868, clock cycles per UART bit.
- Derived W = TD_WIDTH+$clog2(NEURON_NO).
- Elaboration error unless W <= UART_DATA_LEN*UART_CYC. Unused upper bits are zero-padded.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tx_en  in  1  streaming enable (level).
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  W  FIFO read data. Valid on the cycle after fifo_rd.
- fifo_rd  out  1  one-cycle FIFO pop strobe.
- tx_dout  out  1  UART serial line, idle high.
- busy  out  1  high whenever the state is not IDLE.
- word_done  out  1  one-cycle pulse when the last stop bit of a word ends.
- word_cnt  out  16  count of words sent. Wraps 0xFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx_dout=1, fifo_rd=0, busy=0, word_done=0, word_cnt=0. Shift register, bit counter, byte counter and baud counter all clear.
- Reset asserted mid-frame: tx_dout goes to 1 immediately. The word is abandoned and is not re-popped.
- All outputs are registered.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: if tx_en=1 and fifo_empty=0, assert fifo_rd for exactly one cycle and go to POP. Otherwise stay in IDLE.
- POP: wait one cycle for FIFO read latency, then go to LOAD.
- LOAD: capture the zero-padded fifo_dout into the word register and set byte_idx=0. Go to START.
- Byte order: most-significant byte first. Byte k = word[(UART_CYC-k)*UART_DATA_LEN-1 -: UART_DATA_LEN].
- START: tx_dout=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: UART_DATA_LEN bits, LSB first, each held CLKS_PER_BIT cycles. Bit index runs 0..UART_DATA_LEN-1, then go to STOP.
- STOP: tx_dout=1 for CLKS_PER_BIT cycles.
  - If byte_idx < UART_CYC-1: increment byte_idx and go to START, with no extra idle bit.
  - Otherwise: pulse word_done, increment word_cnt, and go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary. tx_dout changes only on bit boundaries.
- Latency: fifo_rd to the first start-bit edge is 2 cycles. Each word takes UART_CYC*(UART_DATA_LEN+2)*CLKS_PER_BIT cycles on the line.
- Back-to-back words: IDLE samples the FIFO on the cycle after word_done. The inter-word gap is 3 cycles of tx_dout=1 (IDLE, POP, LOAD).
- tx_en deasserted mid-word: the current word finishes, then the block stays in IDLE. tx_en affects only the IDLE pop decision.
- fifo_empty is ignored outside IDLE. A FIFO going empty mid-word has no effect.
- fifo_rd is never asserted while fifo_empty=1, and never asserted twice per word.

Test Plan:
- CLKS_PER_BIT=4, defaults otherwise. FIFO preloaded with 24'hA5_3C_81, tx_en=1 -> one fifo_rd pulse, then tx line decodes bytes A5, 3C, 81 in that order.
  - Each frame: start 0, LSB-first bits, stop 1, 40 cycles per byte.
  - word_done pulses once after 120 line cycles; word_cnt=1.
- Two words queued (24'h000001, 24'hFFFFFF) -> second fifo_rd exactly 1 cycle after the first word_done. The 3-cycle high gap is measured. word_cnt=2.
- fifo_empty=1, tx_en=1 for 500 cycles -> fifo_rd never asserted, tx_dout=1 constant, busy=0.
- tx_en dropped during byte 1 of a word -> all 3 bytes still sent, then busy=0. No further pop although fifo_empty=0.
- reset pulsed low during DATA of byte 2 -> tx_dout=1 within the same cycle, and all outputs return to reset values. After release with tx_en=1, the next FIFO entry is sent intact.
- word_cnt forced near wrap: 0xFFFF words sent, then 1 more -> word_cnt=0.
